tetrimino_rotator: RTL and testbench
====================================

Name: tetrimino_rotator

Overview:
- Parametrised successor to the 8x8 spinner.
- Holds a piece as type / rotation / anchor rather than re-encoding an LED matrix.
- Rotates the piece CW or CCW, then tries up to NUM_KICKS wall-kick offsets against a snapshot of the fixed matrix.
- Returns the first legal pose and a rendered active matrix. It sits between the game controller (input decode) and the display/merge logic.

Parameters:
- ROWS, 8, matrix rows; row 0 is the top.
- COLS, 8, matrix columns; col 0 is the left.
- NUM_KICKS, 4, kick offsets tried (1..4). Kick 0 is always the plain rotation.
- AW, $clog2(max(ROWS,COLS))+2, signed width of anchor coordinates.

Ports:
- clk  in  1  single clock; all state on posedge.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  rotation request.
- req_ready  out  1  high only in IDLE.
- req_dir  in  1  0=CW, 1=CCW.
- piece_type  in  3  0=none, 1=L, 2=O, 3=S, 4=T, 5=Z, 6=I, 7=J.
- rot_in  in  2  current rotation state 0..3.
- anchor_row  in  AW  signed top-left row of the 4x4 shape box.
- anchor_col  in  AW  signed top-left col of the 4x4 shape box.
- fixed_matrix  in  [ROWS-1:0][COLS-1:0]  locked cells.
- rsp_valid  out  1  one-cycle result pulse.
- rsp_ok  out  1  rotation accepted.
- rot_out  out  2  resulting rotation.
- row_out, col_out  out  AW  resulting anchor.
- kick_idx  out  2  kick that succeeded (0 on fail).
- active_matrix  out  [ROWS-1:0][COLS-1:0]  rendered result pose.

Behaviour:
- Reset is asynchronous and active-low; there is one clock. While reset_n=0:
  - state=IDLE;
  - all outputs 0 except req_ready=1;
  - an in-flight operation is discarded and no rsp_valid is produced.
- States: IDLE -> CHECK -> RESP -> IDLE.
- IDLE:
  - On req_valid&req_ready, latch type, rot_in, anchor, dir and fixed_matrix (snapshot; later changes to fixed_matrix are ignored).
  - Compute target rot = rot_in+1 mod 4 (CW) or rot_in-1 mod 4 (CCW); 3->0 and 0->3 wrap.
  - Set k=0 and go to CHECK.
- CHECK:
  - Evaluate kick k in one cycle.
  - Cells = anchor + shape_rom(type, target rot) + kick(k).
  - Legal iff all 4 cells satisfy 0<=r<ROWS, 0<=c<COLS and none is set in the snapshot.
  - Legal: load result regs (rot_out=target, row/col=anchor+kick, kick_idx=k, rsp_ok=1) and go to RESP.
  - Illegal with k<NUM_KICKS-1: k++.
  - Illegal with k=NUM_KICKS-1: load the unchanged input pose, rsp_ok=0, kick_idx=0, go to RESP.
  - type=0: fail on the first CHECK cycle, no kicks tried.
- RESP: rsp_valid=1 for exactly one cycle; outputs hold their values until the next RESP; return to IDLE.
- Latency (accept edge = cycle 0):
  - success at kick k: rsp_valid in cycle 2+k;
  - total fail: cycle 1+NUM_KICKS;
  - type=0: cycle 2.
- Kick table (dr,dc): K0 (0,0), K1 (0,-1), K2 (0,+1), K3 (-1,0). For I, K1/K2 use dc=-2/+2.
- Shape ROM (SRS, in the 4x4 box):
  - T/S/Z/J/L use the top-left 3x3.
  - I uses the 4x4: rot0 row1, rot1 col2, rot2 row2, rot3 col1.
  - O is cells (0,1),(0,2),(1,1),(1,2) for every rotation.
  - T rot0 (0,1),(1,0),(1,1),(1,2); T rot1 (0,1),(1,1),(1,2),(2,1).
- Arithmetic: signed AW-bit adds; no overflow is possible for anchors in -3..max(ROWS,COLS)-1.
- active_matrix is registered on the RESP load edge. It renders the result pose (on fail, the input pose), with out-of-range cells dropped.
- Requests while not IDLE: req_ready=0, so they are not accepted. The requester holds req_valid.

Test Plan:
- T, rot0, anchor(2,3), CW, empty field -> rsp_valid cycle 2; rsp_ok=1, rot_out=1, kick_idx=0, anchor(2,3); active cells (2,4),(3,4),(3,5),(4,4).
- I, rot1, anchor(0,5), CW (rot2 would occupy cols 5..8) -> K1 col-2 passes; rsp_valid cycle 3; rot_out=2, col_out=3, kick_idx=1.
- Any piece with the 3x3 box surrounded by fixed cells so all 4 kicks collide -> rsp_valid cycle 5; rsp_ok=0; rot/anchor unchanged; active_matrix = input pose.
- L, rot0, CCW, empty field -> rot_out=3; then J, rot3, CW -> rot_out=0 (wrap both ways).
- Change fixed_matrix in cycle 1 after accept -> result computed from the cycle-0 snapshot. A second req_valid during CHECK is not accepted (req_ready=0).
- Drop reset_n in cycle 1 of a request -> outputs 0 immediately; no rsp_valid; req_ready=1. A new request after release completes normally.

Source files
------------

// File: rtl/tetrimino_rotator.sv
// Rotates a tetrimino held as type/rotation/anchor, trying wall-kick offsets
// against a snapshot of the locked cells and rendering the resulting pose.
module tetrimino_rotator #(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int NUM_KICKS = 4,
    parameter int AW        = $clog2((ROWS > COLS) ? ROWS : COLS) + 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_dir,
    input  logic [2:0]                piece_type,
    input  logic [1:0]                rot_in,
    input  logic signed [AW-1:0]      anchor_row,
    input  logic signed [AW-1:0]      anchor_col,
    input  logic [ROWS-1:0][COLS-1:0] fixed_matrix,
    output logic                      rsp_valid,
    output logic                      rsp_ok,
    output logic [1:0]                rot_out,
    output logic signed [AW-1:0]      row_out,
    output logic signed [AW-1:0]      col_out,
    output logic [1:0]                kick_idx,
    output logic [ROWS-1:0][COLS-1:0] active_matrix
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RESP} state_t;

    state_t                    r_state;
    logic [2:0]                r_type;
    logic [1:0]                r_rot_in;
    logic [1:0]                r_rot_tgt;
    logic signed [AW-1:0]      r_ar;
    logic signed [AW-1:0]      r_ac;
    logic [ROWS-1:0][COLS-1:0] r_snap;
    logic [1:0]                r_k;
    logic                      r_ready;
    logic                      r_rsp_valid;
    logic                      r_rsp_ok;
    logic [1:0]                r_rot_out;
    logic signed [AW-1:0]      r_row_out;
    logic signed [AW-1:0]      r_col_out;
    logic [1:0]                r_kick_idx;
    logic [ROWS-1:0][COLS-1:0] r_active;

    logic [15:0]               w_mask_tgt;
    logic [15:0]               w_mask_in;
    logic signed [AW-1:0]      w_kdr;
    logic signed [AW-1:0]      w_kdc;
    logic signed [AW-1:0]      w_kr;
    logic signed [AW-1:0]      w_kc;
    logic [ROWS-1:0][COLS-1:0] w_cand;
    logic [ROWS-1:0][COLS-1:0] w_in_pose;
    logic                      w_inb;
    logic                      w_legal;

    // 4x4 box bitmask: bit (4*row + col), row 0 / col 0 at top-left.
    function automatic logic [15:0] shape_mask(input logic [2:0] t, input logic [1:0] rt);
        logic [15:0] m;
        m = '0;
        case ({t, rt})
            5'b001_00: m = 16'h0074;  5'b001_01: m = 16'h0622;
            5'b001_10: m = 16'h0170;  5'b001_11: m = 16'h0223;
            5'b010_00, 5'b010_01, 5'b010_10, 5'b010_11: m = 16'h0066;
            5'b011_00: m = 16'h0036;  5'b011_01: m = 16'h0462;
            5'b011_10: m = 16'h0360;  5'b011_11: m = 16'h0231;
            5'b100_00: m = 16'h0072;  5'b100_01: m = 16'h0262;
            5'b100_10: m = 16'h0270;  5'b100_11: m = 16'h0232;
            5'b101_00: m = 16'h0063;  5'b101_01: m = 16'h0264;
            5'b101_10: m = 16'h0630;  5'b101_11: m = 16'h0132;
            5'b110_00: m = 16'h00F0;  5'b110_01: m = 16'h4444;
            5'b110_10: m = 16'h0F00;  5'b110_11: m = 16'h2222;
            5'b111_00: m = 16'h0071;  5'b111_01: m = 16'h0226;
            5'b111_10: m = 16'h0470;  5'b111_11: m = 16'h0322;
            default:   m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [ROWS-1:0][COLS-1:0] render(input logic [15:0] mask,
                                                         input logic signed [AW-1:0] ar,
                                                         input logic signed [AW-1:0] ac);
        logic [ROWS-1:0][COLS-1:0] m;
        logic signed [AW-1:0]      cr;
        logic signed [AW-1:0]      cc;
        m = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            cr = ar + AW'(i >> 2);
            cc = ac + AW'(i & 32'd3);
            for (int unsigned r = 0; r < ROWS; r++)
                for (int unsigned c = 0; c < COLS; c++)
                    if (mask[i] && cr == AW'(r) && cc == AW'(c))
                        m[r][c] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic all_in_range(input logic [15:0] mask,
                                          input logic signed [AW-1:0] ar,
                                          input logic signed [AW-1:0] ac);
        logic                 ok;
        logic signed [AW-1:0] cr;
        logic signed [AW-1:0] cc;
        ok = 1'b1;
        for (int unsigned i = 0; i < 16; i++) begin
            cr = ar + AW'(i >> 2);
            cc = ac + AW'(i & 32'd3);
            if (mask[i] && (cr[AW-1] || cc[AW-1] || cr >= AW'(ROWS) || cc >= AW'(COLS)))
                ok = 1'b0;
        end
        return ok;
    endfunction

    // I piece kicks two columns sideways; everything else one.
    always_comb begin
        w_kdr = '0;
        w_kdc = '0;
        case (r_k)
            2'd1:    w_kdc = (r_type == 3'd6) ? AW'(-2) : AW'(-1);
            2'd2:    w_kdc = (r_type == 3'd6) ? AW'(2)  : AW'(1);
            2'd3:    w_kdr = AW'(-1);
            default: ;
        endcase
    end

    always_comb begin
        w_mask_tgt = shape_mask(r_type, r_rot_tgt);
        w_mask_in  = shape_mask(r_type, r_rot_in);
        w_kr       = r_ar + w_kdr;
        w_kc       = r_ac + w_kdc;
        w_cand     = render(w_mask_tgt, w_kr, w_kc);
        w_in_pose  = render(w_mask_in, r_ar, r_ac);
        w_inb      = all_in_range(w_mask_tgt, w_kr, w_kc);
        w_legal    = (r_type != 3'd0) && w_inb && !(|(w_cand & r_snap));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_type      <= '0;
            r_rot_in    <= '0;
            r_rot_tgt   <= '0;
            r_ar        <= '0;
            r_ac        <= '0;
            r_snap      <= '0;
            r_k         <= '0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_ok    <= 1'b0;
            r_rot_out   <= '0;
            r_row_out   <= '0;
            r_col_out   <= '0;
            r_kick_idx  <= '0;
            r_active    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_type    <= piece_type;
                        r_rot_in  <= rot_in;
                        r_rot_tgt <= req_dir ? rot_in - 2'd1 : rot_in + 2'd1;
                        r_ar      <= anchor_row;
                        r_ac      <= anchor_col;
                        r_snap    <= fixed_matrix;
                        r_k       <= '0;
                        r_ready   <= 1'b0;
                        r_state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_legal) begin
                        r_rsp_ok    <= 1'b1;
                        r_rot_out   <= r_rot_tgt;
                        r_row_out   <= w_kr;
                        r_col_out   <= w_kc;
                        r_kick_idx  <= r_k;
                        r_active    <= w_cand;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_type == 3'd0 || r_k == 2'(NUM_KICKS - 1)) begin
                        r_rsp_ok    <= 1'b0;
                        r_rot_out   <= r_rot_in;
                        r_row_out   <= r_ar;
                        r_col_out   <= r_ac;
                        r_kick_idx  <= '0;
                        r_active    <= w_in_pose;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_k <= r_k + 2'd1;
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_ready     <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_ready     <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = r_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_ok        = r_rsp_ok;
    assign rot_out       = r_rot_out;
    assign row_out       = r_row_out;
    assign col_out       = r_col_out;
    assign kick_idx      = r_kick_idx;
    assign active_matrix = r_active;

endmodule

// File: tb/tb_tetrimino_rotator.sv
// Bench for tetrimino_rotator: directed scenarios plus random poses/fields,
// checked against a coordinate-list model of rotation and wall kicks.
module tb_tetrimino_rotator;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int NK   = 4;
    localparam int AW   = 5;

    typedef logic [AW-1:0] aw_t;
    typedef logic [ROWS-1:0][COLS-1:0] mat_t;

    logic          clk;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_dir;
    logic [2:0]    piece_type;
    logic [1:0]    rot_in;
    logic [AW-1:0] anchor_row;
    logic [AW-1:0] anchor_col;
    mat_t          fixed_matrix;
    logic          rsp_valid;
    logic          rsp_ok;
    logic [1:0]    rot_out;
    logic [AW-1:0] row_out;
    logic [AW-1:0] col_out;
    logic [1:0]    kick_idx;
    mat_t          active_matrix;

    int checks   = 0;
    int failures = 0;

    int sr [8][4][4];
    int sc [8][4][4];

    bit   m_ok;
    int   m_rot, m_row, m_col, m_kick, m_lat;
    mat_t m_mat;

    tetrimino_rotator #(.ROWS(ROWS), .COLS(COLS), .NUM_KICKS(NK), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_dir(req_dir), .piece_type(piece_type), .rot_in(rot_in),
        .anchor_row(anchor_row), .anchor_col(anchor_col), .fixed_matrix(fixed_matrix),
        .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rot_out(rot_out), .row_out(row_out),
        .col_out(col_out), .kick_idx(kick_idx), .active_matrix(active_matrix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic def(input int t, input int r, input int r0, input int c0, input int r1,
                       input int c1, input int r2, input int c2, input int r3, input int c3);
        sr[t][r][0] = r0; sc[t][r][0] = c0;
        sr[t][r][1] = r1; sc[t][r][1] = c1;
        sr[t][r][2] = r2; sc[t][r][2] = c2;
        sr[t][r][3] = r3; sc[t][r][3] = c3;
    endtask

    task automatic init_shapes();
        def(1,0, 0,2, 1,0, 1,1, 1,2); def(1,1, 0,1, 1,1, 2,1, 2,2);
        def(1,2, 1,0, 1,1, 1,2, 2,0); def(1,3, 0,0, 0,1, 1,1, 2,1);
        for (int r = 0; r < 4; r++) def(2,r, 0,1, 0,2, 1,1, 1,2);
        def(3,0, 0,1, 0,2, 1,0, 1,1); def(3,1, 0,1, 1,1, 1,2, 2,2);
        def(3,2, 1,1, 1,2, 2,0, 2,1); def(3,3, 0,0, 1,0, 1,1, 2,1);
        def(4,0, 0,1, 1,0, 1,1, 1,2); def(4,1, 0,1, 1,1, 1,2, 2,1);
        def(4,2, 1,0, 1,1, 1,2, 2,1); def(4,3, 0,1, 1,0, 1,1, 2,1);
        def(5,0, 0,0, 0,1, 1,1, 1,2); def(5,1, 0,2, 1,1, 1,2, 2,1);
        def(5,2, 1,0, 1,1, 2,1, 2,2); def(5,3, 0,1, 1,0, 1,1, 2,0);
        def(6,0, 1,0, 1,1, 1,2, 1,3); def(6,1, 0,2, 1,2, 2,2, 3,2);
        def(6,2, 2,0, 2,1, 2,2, 2,3); def(6,3, 0,1, 1,1, 2,1, 3,1);
        def(7,0, 0,0, 1,0, 1,1, 1,2); def(7,1, 0,1, 0,2, 1,1, 2,1);
        def(7,2, 1,0, 1,1, 1,2, 2,2); def(7,3, 0,1, 1,1, 2,0, 2,1);
    endtask

    function automatic mat_t paint(input int t, input int rot, input int ar, input int ac);
        mat_t m;
        m = '0;
        if (t != 0)
            for (int n = 0; n < 4; n++) begin
                int r = ar + sr[t][rot][n];
                int c = ac + sc[t][rot][n];
                if (r >= 0 && r < ROWS && c >= 0 && c < COLS) m[r][c] = 1'b1;
            end
        return m;
    endfunction

    task automatic model(input int t, input int rot, input int ar, input int ac,
                         input int dir, input mat_t fld);
        int  tgt;
        bit  found;
        tgt   = dir ? (rot + 3) % 4 : (rot + 1) % 4;
        found = 0;
        m_ok = 0; m_rot = rot; m_row = ar; m_col = ac; m_kick = 0;
        m_lat = (t == 0) ? 2 : 1 + NK;
        if (t != 0)
            for (int k = 0; k < NK && !found; k++) begin
                int  dr = (k == 3) ? -1 : 0;
                int  dc = (k == 1) ? ((t == 6) ? -2 : -1) : (k == 2) ? ((t == 6) ? 2 : 1) : 0;
                bit  legal = 1;
                for (int n = 0; n < 4; n++) begin
                    int r = ar + dr + sr[t][tgt][n];
                    int c = ac + dc + sc[t][tgt][n];
                    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) legal = 0;
                    else if (fld[r][c]) legal = 0;
                end
                if (legal) begin
                    found = 1; m_ok = 1; m_rot = tgt;
                    m_row = ar + dr; m_col = ac + dc; m_kick = k; m_lat = 2 + k;
                end
            end
        m_mat = paint(t, m_rot, m_row, m_col);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, ".rsp_ok"},    64'(rsp_ok),    64'd0);
        chk({tag, ".rot_out"},   64'(rot_out),   64'd0);
        chk({tag, ".row_out"},   64'(row_out),   64'd0);
        chk({tag, ".col_out"},   64'(col_out),   64'd0);
        chk({tag, ".kick_idx"},  64'(kick_idx),  64'd0);
        chk({tag, ".active"},    64'(active_matrix), 64'd0);
        chk({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    endtask

    task automatic do_req(input string tag, input int t, input int rot, input int ar,
                          input int ac, input int dir, input bit hold, input bit scramble);
        mat_t saved;
        bit   seen;
        int   n;
        saved = fixed_matrix;
        model(t, rot, ar, ac, dir, fixed_matrix);
        @(negedge clk);
        piece_type = 3'(t);
        rot_in     = 2'(rot);
        anchor_row = aw_t'(ar);
        anchor_col = aw_t'(ac);
        req_dir    = 1'(dir);
        req_valid  = 1'b1;
        chk({tag, ".ready_idle"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        seen = 0;
        n    = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            n = i;
            if (i == 1) begin
                chk({tag, ".ready_busy"}, 64'(req_ready), 64'd0);
                if (scramble) fixed_matrix = '1;
            end
            if (rsp_valid) seen = 1;
        end
        req_valid = 1'b0;
        chk({tag, ".rsp_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({tag, ".latency"},  64'(n),        64'(m_lat));
            chk({tag, ".rsp_ok"},   64'(rsp_ok),   64'(m_ok));
            chk({tag, ".rot_out"},  64'(rot_out),  64'(m_rot));
            chk({tag, ".row_out"},  64'(row_out),  64'(aw_t'(m_row)));
            chk({tag, ".col_out"},  64'(col_out),  64'(aw_t'(m_col)));
            chk({tag, ".kick_idx"}, 64'(kick_idx), 64'(m_kick));
            chk({tag, ".active"},   64'(active_matrix), 64'(m_mat));
            @(negedge clk);
            chk({tag, ".pulse_end"}, 64'(rsp_valid), 64'd0);
            chk({tag, ".ready_back"}, 64'(req_ready), 64'd1);
            chk({tag, ".ok_hold"},   64'(rsp_ok),   64'(m_ok));
        end
        fixed_matrix = saved;
    endtask

    initial begin
        init_shapes();
        reset_n = 1'b1; req_valid = 1'b0; req_dir = 1'b0; piece_type = '0;
        rot_in = '0; anchor_row = '0; anchor_col = '0; fixed_matrix = '0;
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        do_req("t_plain", 4, 0, 2, 3, 0, 0, 0);
        do_req("i_kick1", 6, 1, 0, 5, 0, 0, 0);

        // Boxed-in T: only the input pose's own cells are free.
        fixed_matrix = '1;
        fixed_matrix[2][3] = 1'b0; fixed_matrix[3][2] = 1'b0;
        fixed_matrix[3][3] = 1'b0; fixed_matrix[3][4] = 1'b0;
        do_req("boxed", 4, 0, 2, 2, 0, 0, 0);
        fixed_matrix = '0;

        do_req("l_ccw_wrap", 1, 0, 3, 3, 1, 0, 0);
        do_req("j_cw_wrap",  7, 3, 3, 3, 0, 0, 0);
        do_req("none_type",  0, 2, 3, 3, 0, 0, 0);
        do_req("snapshot",   4, 0, 2, 3, 0, 1, 1);
        do_req("top_kick3",  6, 0, 5, 0, 0, 0, 0);

        // Reset dropped one cycle into a request discards it.
        @(negedge clk);
        piece_type = 3'd4; rot_in = 2'd0; anchor_row = aw_t'(2); anchor_col = aw_t'(3);
        req_dir = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("midreset.quiet%0d", i), 64'(rsp_valid), 64'd0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("postreset.quiet%0d", i), 64'(rsp_valid), 64'd0);
        end
        do_req("after_reset", 5, 1, 1, 2, 1, 0, 0);

        for (int it = 0; it < 80; it++) begin
            for (int r = 0; r < ROWS; r++)
                fixed_matrix[r] = (it % 4 == 0) ? '0 : COLS'($urandom & $urandom);
            do_req($sformatf("rnd%0d", it), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 10)) - 3,
                   int'($urandom_range(0, 10)) - 3, int'($urandom_range(0, 1)),
                   (it % 5) == 1, (it % 7) == 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
